// File: rtl/pow_div_top.sv
// pow_div_top: registered power-then-divide datapath.
//
// Computes output_value = floor(x*x / (2^W-1)) through a fixed 3-stage pipeline. It accepts one
// new sample per clock and has no handshake.
//   Stage 1: capture the operand.
//   Stage 2: square it at full 2W-bit width.
//   Stage 3: divide by the full-scale value and register the quotient.
//
// Ports:
//   clk           in   1  system clock, rising-edge active
//   rst           in   1  asynchronous active-low reset; clears every pipeline register
//   initial_value in   W  unsigned operand x, sampled every rising edge
//   output_value  out  W  registered result floor(x*x/(2^W-1))

module pow_div_top #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] initial_value,
    output logic [W-1:0] output_value
);

    // Full-scale divisor, one bit wider so the partial remainder compares without overflow.
    localparam logic [W:0] Divisor = {1'b0, {W{1'b1}}};

    logic [W-1:0]   x_q;
    logic [2*W-1:0] p_q;

    logic [W:0]     rem;
    logic [W-1:0]   quo;
    logic           rem_ge;

    // Unrolled restoring divider over all 2W dividend bits.
    // The partial remainder stays below Divisor after each step. Its top bit is therefore zero
    // before every shift, so W+1 bits are enough.
    // Quotient bits are shifted in MSB-first, and only the last W of them are kept. The dropped
    // upper bits are always zero because x*x <= (2^W-1)^2 gives a quotient that fits in W bits.
    always_comb begin
        rem    = '0;
        quo    = '0;
        rem_ge = 1'b0;
        for (int i = int'(2 * W) - 1; i >= 0; i--) begin
            rem    = {rem[W-1:0], p_q[i]};
            rem_ge = (rem >= Divisor);
            if (rem_ge) begin
                rem = rem - Divisor;
            end
            quo = {quo[W-2:0], rem_ge};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q          <= '0;
            p_q          <= '0;
            output_value <= '0;
        end else begin
            x_q          <= initial_value;
            p_q          <= {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
            output_value <= quo;
        end
    end

endmodule

// File: tb/tb_pow_div_top.sv
// Directed bench for pow_div_top (W=8).
// Inputs change on the falling edge, and outputs are sampled on the falling edge before new
// inputs are driven. A value driven at falling edge t is therefore visible at falling edge t+3.

module tb_pow_div_top;

    logic       clk;
    logic       rst;
    logic [7:0] initial_value;
    logic [7:0] output_value;

    int vectors;
    int miscompares;

    pow_div_top #(
        .W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .initial_value(initial_value),
        .output_value (output_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer reference for floor(x*x/255).
    function automatic logic [7:0] ref_f(input int x);
        int q;
        q = (x * x) / 255;
        return q[7:0];
    endfunction

    task automatic test_reset();
        // Hold reset with full-scale input; output must stay cleared.
        rst           = 1'b0;
        initial_value = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (output_value !== 8'h00) begin
                $display("FAIL reset_hold[%0d]: got %0h expected 00", i, output_value);
                miscompares++;
            end
        end
        // Release, let 0xFF reach the output, then reset asynchronously mid-cycle.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (output_value !== 8'hFF) begin
            $display("FAIL reset_prefill: got %0h expected ff", output_value);
            miscompares++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (output_value !== 8'h00) begin
            $display("FAIL reset_async: got %0h expected 00", output_value);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (output_value !== 8'h00) begin
            $display("FAIL reset_async_hold: got %0h expected 00", output_value);
            miscompares++;
        end
    endtask

    task automatic test_directed();
        logic [7:0] vin [5];
        logic [7:0] vexp[5];
        vin  = '{8'hAA, 8'h00, 8'hFF, 8'h55, 8'h01};
        vexp = '{8'h71, 8'h00, 8'hFF, 8'h1C, 8'h00};
        rst  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            initial_value = vin[i];
            repeat (3) @(negedge clk);
            vectors++;
            if (output_value !== vexp[i]) begin
                $display("FAIL directed_%0h: got %0h expected %0h", vin[i], output_value,
                         vexp[i]);
                miscompares++;
            end
            repeat (2) @(negedge clk);
            // Constant input must hold steady.
            vectors++;
            if (output_value !== vexp[i]) begin
                $display("FAIL steady_%0h: got %0h expected %0h", vin[i], output_value,
                         vexp[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_latency();
        initial_value = 8'h00;
        repeat (3) @(negedge clk);
        initial_value = 8'h80;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if (output_value !== ((i == 3) ? 8'h40 : 8'h00)) begin
                $display("FAIL latency_edge%0d: got %0h expected %0h", i, output_value,
                         (i == 3) ? 8'h40 : 8'h00);
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[4];
        logic [7:0] exq[4];
        seq = '{8'h10, 8'h0F, 8'hFF, 8'h00};
        exq = '{8'h01, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) begin
                vectors++;
                if (output_value !== exq[i-3]) begin
                    $display("FAIL b2b_%0h: got %0h expected %0h", seq[i-3], output_value,
                             exq[i-3]);
                    miscompares++;
                end
            end
            initial_value = (i < 4) ? seq[i] : 8'h00;
            @(negedge clk);
        end
    endtask

    // Sweep 0..255 one per cycle with a one-cycle reset pulse at cycle Rc.
    // Samples still in flight when reset hits (driven at Rc-2..Rc) must come out as 0.
    task automatic test_sweep_reset();
        localparam int Rc = 100;
        localparam int N  = 259;
        logic [7:0] xs [N];
        logic       vld[N];
        logic [7:0] exp_v;
        for (int c = 0; c < N; c++) begin
            if (c >= 3 && vld[c-3]) begin
                exp_v = ref_f(int'(xs[c-3]));
            end else begin
                exp_v = 8'h00;
            end
            vectors++;
            if (output_value !== exp_v) begin
                $display("FAIL sweep_c%0d: got %0h expected %0h", c, output_value, exp_v);
                miscompares++;
            end
            if (c == Rc) begin
                rst = 1'b0;
                #1;
                vectors++;
                if (output_value !== 8'h00) begin
                    $display("FAIL sweep_reset: got %0h expected 00", output_value);
                    miscompares++;
                end
            end
            if (c == Rc + 1) begin
                rst = 1'b1;
            end
            xs[c]         = (c < 256) ? 8'(c) : 8'h00;
            vld[c]        = !(c >= Rc - 2 && c <= Rc);
            initial_value = xs[c];
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        test_sweep_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pow_div_top.md
Name: pow_div_top

Overview:
- Registered 8-bit "power-then-divide" datapath: squares the unsigned input, then divides by full-scale (2^W-1).
- Result: output_value = floor(x*x / 255) for W=8, a normalized square mapping 0..255 onto 0..255.
- Fixed 3-cycle pipeline, one new sample accepted every clock; no handshake.
- Top-level wrapper of the pow/div datapath, driven directly by board/bench stimulus.

Parameters:
- W, 8, data width of input and output; divisor is fixed at 2^W-1. Only W=8 is required to be verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted). Name kept as rst per codebase convention.
- initial_value  input  W  unsigned operand x, sampled every rising edge.
- output_value  output  W  unsigned result floor(x*x/(2^W-1)), registered.

Behaviour:
- Reset: while rst=0, all pipeline registers and output_value = 0, immediately (asynchronous). Release is synchronous to the next clk rising edge; first capture happens on the first rising edge with rst=1.
- Stage 1 (edge n): x_r <= initial_value.
- Stage 2 (edge n+1): p_r <= x_r * x_r, 2W bits (16 bits, max 65025). No truncation.
- Stage 3 (edge n+2): output_value <= floor(p_r / (2^W-1)).
  - Exact integer quotient, truncated toward zero.
  - Result always fits in W bits (max 255 when x=255).
- Divider: unrolled combinational restoring divider (2W iterations) between p_r and the output register.
  - Reciprocal approximations are permitted only if bit-exact for all 256 inputs.
- Latency: a value present before edge n appears on output_value after edge n+2, i.e. 3 rising edges including the capture edge.
- Throughput: 1 result per cycle. A changing input each cycle produces a matching output stream delayed by 3 cycles.
- Constant input: output settles after 3 edges and then holds steady.
- Reset mid-operation: all in-flight samples are discarded. Output is 0 and stays 0 until 3 edges after reset release with valid input.
- Undriven (X) input: not sanitized. X propagates to the output 3 cycles later. Benches must drive initial_value from reset release.
- Boundaries:
  - x=0 -> 0
  - x=1 -> 0
  - x=15 -> 0 (225/255)
  - x=16 -> 1 (256/255)
  - x=255 -> 255
- No overflow, saturation, or status outputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with initial_value=0xFF -> output_value=0 throughout. Assert rst=0 asynchronously mid-cycle -> output_value goes to 0 without waiting for a clock edge.
- Directed values, each held 5 cycles after reset release (output checked at cycle 3 of each hold):
  - 0xAA -> 0x71 (113)
  - 0x00 -> 0x00
  - 0xFF -> 0xFF
  - 0x55 -> 0x1C (28)
  - 0x01 -> 0x00
- Latency: step the input 0x00 -> 0x80 at edge n -> output stays 0 through edge n+1, then becomes 0x40 (16384/255=64) after edge n+2.
- Back-to-back throughput: drive 0x10, 0x0F, 0xFF, 0x00 on consecutive cycles -> output shows 0x01, 0x00, 0xFF, 0x00 on consecutive cycles, each 3 edges later.
- Exhaustive sweep: drive x=0..255, one per cycle, and compare each output against a reference model floor(x*x/255) with a 3-cycle delay; zero mismatches required.
- Reset mid-stream: during the sweep, pulse rst=0 for 1 cycle -> output is 0 during reset. After release, output is 0 until the first post-reset sample emerges 3 edges later, then matches the model again.
